// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master and the mdu is the slave.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO: WIDTH-step shift-add multiply
// and restoring divide on magnitudes, with sign fix-up in a final FIX cycle.
module mdu #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rstn,
  mdu_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    ONE_AW    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_STEP = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? neg_f(v) : v;
  endfunction

  state_t           state_r, state_s;
  logic             div_r, res_sign_r, rem_sign_r, divz_r;
  logic [WIDTH-1:0] opnd_r, mplier_r, a_orig_r;
  logic [AW-1:0]    acc_r, acc_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, hi_s, lo_s;
  logic             busy_r, done_r;

  logic             accept_md_s, wr_hi_s, wr_lo_s, finish_s, signed_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   msum_s, dtrial_s;
  logic [AW-1:0]    prod_s;

  // Issue decode: only IDLE accepts, and a coincident flush suppresses it.
  always_comb begin
    accept_md_s = 1'b0;
    wr_hi_s     = 1'b0;
    wr_lo_s     = 1'b0;
    if (state_r == IDLE && bus.start && !bus.flush) begin
      case (bus.op)
        3'b000, 3'b001, 3'b010, 3'b011: accept_md_s = 1'b1;
        3'b100:  wr_hi_s = 1'b1;
        3'b101:  wr_lo_s = 1'b1;
        default: accept_md_s = 1'b0;
      endcase
    end else begin
      accept_md_s = 1'b0;
    end
    signed_s = ~bus.op[0];
    mag_a_s  = mag_f(bus.A, signed_s);
    mag_b_s  = mag_f(bus.B, signed_s);
    finish_s = (state_r == FIX) && !bus.flush;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_md_s) state_s = CALC;
        else             state_s = IDLE;
      end
      CALC: begin
        if (bus.flush)               state_s = IDLE;
        else if (cnt_r == LAST_STEP) state_s = FIX;
        else                         state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One iteration step plus the sign fix-up applied in FIX.
  always_comb begin
    msum_s   = {1'b0, acc_r[AW-1:WIDTH]} + {1'b0, (mplier_r[0] ? opnd_r : ZERO_W)};
    // Shifted remainder is WIDTH+1 bits wide, so the borrow is the MSB.
    dtrial_s = acc_r[AW-1:WIDTH-1] - {1'b0, opnd_r};
    if (div_r) begin
      if (!dtrial_s[WIDTH]) acc_s = {dtrial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      else                  acc_s = {acc_r[AW-2:0], 1'b0};
    end else begin
      acc_s = {msum_s, acc_r[WIDTH-1:1]};
    end

    prod_s = res_sign_r ? (~acc_r + ONE_AW) : acc_r;
    if (!div_r) begin
      hi_s = prod_s[AW-1:WIDTH];
      lo_s = prod_s[WIDTH-1:0];
    end else if (divz_r) begin
      hi_s = a_orig_r;
      lo_s = ONES_W;
    end else begin
      hi_s = rem_sign_r ? neg_f(acc_r[AW-1:WIDTH]) : acc_r[AW-1:WIDTH];
      lo_s = res_sign_r ? neg_f(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_r      <= 1'b0;
      res_sign_r <= 1'b0;
      rem_sign_r <= 1'b0;
      divz_r     <= 1'b0;
      opnd_r     <= ZERO_W;
      mplier_r   <= ZERO_W;
      a_orig_r   <= ZERO_W;
      acc_r      <= {AW{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (accept_md_s) begin
      div_r      <= bus.op[1];
      res_sign_r <= signed_s & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      rem_sign_r <= signed_s & bus.A[WIDTH-1];
      divz_r     <= (bus.B == ZERO_W);
      opnd_r     <= bus.op[1] ? mag_b_s : mag_a_s;
      mplier_r   <= bus.op[1] ? ZERO_W : mag_b_s;
      a_orig_r   <= bus.A;
      acc_r      <= bus.op[1] ? {ZERO_W, mag_a_s} : {AW{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (state_r == CALC && !bus.flush) begin
      acc_r    <= acc_s;
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  // Architectural HI/LO and the status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_r   <= ZERO_W;
      lo_r   <= ZERO_W;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (wr_hi_s) begin
        hi_r <= bus.A;
      end else if (wr_lo_s) begin
        lo_r <= bus.A;
      end else if (finish_s) begin
        hi_r <= hi_s;
        lo_r <= lo_s;
      end
      busy_r <= (state_s != IDLE);
      done_r <= finish_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a vector table of mult/div results plus hand-written
// sequences for MTHI/MTLO, start-while-busy, flush and asynchronous reset.
module tb_mdu;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;

  mdu_if #(.WIDTH(32)) bus ();
  mdu #(.WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts busy cycles until idle; hi/lo must hold and done stay low meanwhile.
  task automatic wait_idle(input logic [31:0] old_hi, input logic [31:0] old_lo,
                           output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      if (bus.hi !== old_hi || bus.lo !== old_lo || bus.done !== 1'b0) bad++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad;
    logic [31:0] oh, ol;

    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'b000, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[6]  = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[7]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'b010, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[9]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[11] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[12] = '{3'b010, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};

    rstn = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 3'b000;
    bus.A = 32'h0;
    bus.B = 32'h0;
    tick();
    tick();
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_done", {31'b0, bus.done}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      oh = bus.hi;
      ol = bus.lo;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(oh, ol, cyc, bad);
      chk($sformatf("v%0d_busy_cycles", i), cyc, 32'd33);
      chk($sformatf("v%0d_hold", i), bad, 32'd0);
      chk($sformatf("v%0d_done", i), {31'b0, bus.done}, 32'h1);
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      tick();
      chk($sformatf("v%0d_done_once", i), {31'b0, bus.done}, 32'h0);
    end

    // MTHI then MTLO on consecutive cycles.
    bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'h12345678;
    tick();
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_busy", {31'b0, bus.busy}, 32'h0);
    bus.op = 3'b101; bus.A = 32'h9ABCDEF0;
    tick();
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", bus.hi, 32'h12345678);
    chk("mtlo_busy", {31'b0, bus.busy}, 32'h0);
    chk("mtlo_done", {31'b0, bus.done}, 32'h0);

    // Reserved opcode changes nothing.
    issue(3'b110, 32'hDEADBEEF, 32'h1);
    chk("op110_hi", bus.hi, 32'h12345678);
    chk("op110_lo", bus.lo, 32'h9ABCDEF0);
    chk("op110_busy", {31'b0, bus.busy}, 32'h0);

    // DIVU 100/7 with an extra MTHI start at step 10 that must be ignored.
    issue(3'b011, 32'd100, 32'd7);
    repeat (10) tick();
    bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'hCAFEF00D;
    tick();
    bus.start = 1'b0;
    wait_idle(32'h12345678, 32'h9ABCDEF0, cyc, bad);
    chk("repulse_cycles", cyc, 32'd22);
    chk("repulse_hold", bad, 32'd0);
    chk("repulse_hi", bus.hi, 32'd2);
    chk("repulse_lo", bus.lo, 32'd14);

    // Flush at step 15 of a MULT.
    issue(3'b000, 32'd3, 32'd5);
    repeat (15) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'h0);
    chk("flush_hi", bus.hi, 32'd2);
    chk("flush_lo", bus.lo, 32'd14);
    cyc = 0;
    repeat (40) begin
      if (bus.done) cyc++;
      tick();
    end
    chk("flush_no_done", cyc, 32'd0);
    chk("flush_after_lo", bus.lo, 32'd14);

    // Flush in IDLE wins over a coincident start.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b100; bus.A = 32'h55;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_hi", bus.hi, 32'd2);

    // Asynchronous reset at step 20, checked between clock edges.
    issue(3'b000, 32'hFFFFFFFD, 32'd5);
    repeat (20) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("areset_hi", bus.hi, 32'h0);
    chk("areset_lo", bus.lo, 32'h0);
    chk("areset_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    issue(3'b000, 32'd3, 32'd5);
    wait_idle(32'h0, 32'h0, cyc, bad);
    chk("post_reset_cycles", cyc, 32'd33);
    chk("post_reset_hi", bus.hi, 32'h0);
    chk("post_reset_lo", bus.lo, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit that owns the HI/LO register pair for the pipelined CPU. It sits beside the ALU in the EX stage and executes MULT, MULTU, DIV and DIVU as 32-step shift-add or restoring-divide sequences. It also services MTHI/MTLO writes. The pipeline issues operations with `start`, stalls on `busy`, and reads `hi`/`lo` directly.

## Interface

- `WIDTH`, default 32: operand width; HI/LO are each WIDTH bits, and the iteration count equals WIDTH.
- `clk`  in  1  rising-edge clock
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  issue request; accepted only in IDLE
- `op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
  - 110 and 111 are ignored (no state change)
- `A`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
- `B`  in  WIDTH  rt operand: multiplier or divisor
- `flush`  in  1  abort the in-flight operation (pipeline flush)
- `busy`  out  1  high while an operation is in flight; the pipeline stalls on it
- `done`  out  1  one-cycle pulse when HI/LO have been updated by a mult/div
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation

- States are IDLE, CALC and FIX. A 5-bit step counter counts steps 0..31.
- **IDLE + `start` + mult/div op:**
  - Latch the op.
  - Latch |A| and |B| for signed ops; latch raw A and B for unsigned ops.
  - Latch the result sign flags:
    - product sign = A[31]^B[31];
    - quotient sign = A[31]^B[31];
    - remainder sign = A[31].
  - Clear the accumulator and counter, then go to CALC.
- **IDLE + `start` + MTHI/MTLO:**
  - `hi` (or `lo`) <= A at that edge.
  - No busy, no done; remain in IDLE.
- **CALC, multiply:** each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator, then shift the accumulator right by 1 (carry included).
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first.
  - Shift {rem, quot} left by 1.
  - Trial-subtract the divisor from rem.
  - If there is no borrow, keep the difference and set quot[0]=1.
- **CALC exit:** when the counter reaches 31, go to FIX.
- **FIX:** apply signs and load `hi`/`lo`, then return to IDLE.
  - Signed multiply: negate the 64-bit product if the product sign is set. `hi` = product[63:32], `lo` = product[31:0].
  - Signed divide: negate the quotient if its sign flag is set; negate the remainder if its sign flag is set. `lo` = quotient, `hi` = remainder.
  - Divide by zero (divisor latched as 0), signed or unsigned: `lo` = 32'hFFFFFFFF, `hi` = A as latched at issue (original signed value, not |A|).
  - DIV 0x80000000 / -1: `lo` = 0x80000000, `hi` = 0. This falls out naturally from the abs/negate path.
- **`start` while busy:** ignored; the pipeline is responsible for stalling.
- **`flush` in CALC or FIX:** return to IDLE at the next edge. `hi`/`lo` are unchanged and no done pulse is produced. `flush` in IDLE has no effect and takes priority over a coincident `start`.
- **Reset (async, any state):** state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0. The in-flight result is discarded.

## Timing

- `start` is sampled at edge T0.
- `busy` is registered and high from after T0 through the cycle ending at edge T33: 32 CALC cycles plus 1 FIX cycle.
- `hi`/`lo` update at edge T33.
- `done` is high for exactly the cycle after T33; `busy` is low in that same cycle.
- A new `start` may be accepted at edge T34, i.e. back-to-back issue when `start` is held.
- MTHI/MTLO: the register updates at the accept edge; a read in the next cycle sees the new value.
- `hi`/`lo` hold their old values throughout CALC.

## Test plan

- MULT A=-3 (FFFFFFFD), B=5 -> after 34 cycles `hi`=FFFFFFFF, `lo`=FFFFFFF1; `done` pulses once; `busy` is high for exactly 33 cycles.
- MULTU A=FFFFFFFF, B=FFFFFFFF -> `hi`=FFFFFFFE, `lo`=00000001.
- DIV A=-7, B=2 -> `lo`=FFFFFFFD, `hi`=FFFFFFFF.
- DIVU A=7, B=0 -> `lo`=FFFFFFFF, `hi`=7.
- DIV A=80000000, B=FFFFFFFF -> `lo`=80000000, `hi`=0.
- MTHI A=12345678, then MTLO A=9ABCDEF0 on consecutive cycles -> `hi`/`lo` update the edge after each issue with no busy.
- DIVU 100/7 with `start` re-pulsed at step 10 -> the extra `start` is ignored; `lo`=14, `hi`=2.
- `flush` at step 15 of a MULT -> IDLE next cycle, `hi`/`lo` unchanged, no done.
- `rstn` low at step 20 -> all outputs 0 immediately, without waiting for a clock edge.
